alu_exec_unit: RTL and testbench

Execution-stage ALU that consumes the 4-bit ALU control code produced by the decode-side ALU control logic and performs the selected operation on two XLEN-bit operands. Single-cycle operations (AND, OR, ADD, SUB, SLT) produce a registered result one cycle after acceptance. Shifts (SLL, SRA) run iteratively at one bit per cycle. A valid/ready handshake on both sides lets the pipeline control stall around multi-cycle shifts.

---
 rtl/alu_exec_unit.sv | 124 ++++++++++++
 tb/tb_alu_exec_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes on both sides.
// AND/OR/ADD/SUB/SLT and unsupported codes finish in one cycle.
// SLL/SRA shift one bit per cycle, so a shift by n takes n cycles.
// Only XLEN = 32 is supported, because the shift amount is always src_b[4:0].
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      count;       // shift steps still to perform
    logic            shift_left;  // direction of the shift in progress

    logic            is_shift;
    logic [4:0]      shamt;
    logic [XLEN-1:0] single_res;
    logic            single_illegal;
    logic [XLEN-1:0] shift_next;

    // The handshake outputs depend on the state alone.
    // There is no combinational path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shamt     = src_b[4:0];

    // Decode the incoming code and compute the single-cycle result.
    // Also compute the next step of the shift register.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
        is_shift       = 1'b0;
        single_res     = '0;
        single_illegal = 1'b0;
        case (alu_ctrl)
            OP_AND: single_res = src_a & src_b;
            OP_OR:  single_res = src_a | src_b;
            OP_ADD: single_res = src_a + src_b;
            OP_SUB: single_res = src_a - src_b;
            OP_SLT: single_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL,
            OP_SRA: is_shift = 1'b1;
            default: single_illegal = 1'b1;
        endcase
        // The shifted value is held in result, so a shift moves result by one bit.
        // A right shift copies the sign bit into the vacated position.
        shift_next = shift_left ? {result[XLEN-2:0], 1'b0}
                                : {result[XLEN-1], result[XLEN-1:1]};
    end

    // Control FSM and datapath registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
            state      <= IDLE;
            result     <= '0;
            zero       <= 1'b0;
            illegal    <= 1'b0;
            count      <= '0;
            shift_left <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift) begin
                            illegal    <= 1'b0;
                            shift_left <= (alu_ctrl == OP_SLL);
                            result     <= src_a;
                            if (shamt == 5'd0) begin
                                zero  <= (src_a == '0);
                                state <= DONE;
                            end else begin
                                count <= shamt;
                                state <= SHIFT;
                            end
                        end else begin
                            result  <= single_res;
                            zero    <= (single_res == '0);
                            illegal <= single_illegal;
                            state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result <= shift_next;
                    count  <= count - 5'd1;
                    if (count == 5'd1) begin
                        zero  <= (shift_next == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Latency is counted in cycles after the accepting edge.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Drives one request in IDLE and waits for the accepting edge.
    // It then scrambles the inputs and counts cycles until out_valid (bounded).
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        alu_ctrl = code; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctrl = 4'b0110; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if ({zero, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {zero, illegal}); end
    endtask

    task automatic test_add_sub();
        int lat;
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got=%h exp=80000000", result); end
        checks++; if ({zero, illegal} !== 2'b00) begin errors++; $display("FAIL add_flags got=%b exp=00", {zero, illegal}); end
        consume();
        issue(4'b0110, 32'h1234, 32'h1234, lat);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sub_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got=%b exp=1", zero); end
        consume();
        issue(4'b0110, 32'h0, 32'h1, lat);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap got=%h exp=ffffffff", result); end
        consume();
    endtask

    task automatic test_slt_logic();
        int lat;
        issue(4'b1000, 32'hFFFF_FFFF, 32'h1, lat);
        checks++; if (result !== 32'h1) begin errors++; $display("FAIL slt_neg got=%h exp=1", result); end
        consume();
        issue(4'b1000, 32'h1, 32'hFFFF_FFFF, lat);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL slt_pos got=%h exp=0", result); end
        consume();
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        checks++; if (result !== 32'h00F0_00F0) begin errors++; $display("FAIL and_result got=%h exp=00f000f0", result); end
        consume();
        issue(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        checks++; if (result !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or_result got=%h exp=fff0fff0", result); end
        consume();
    endtask

    task automatic test_shift();
        int lat;
        issue(4'b1001, 32'h1, 32'd31, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result got=%h exp=80000000", result); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sll31_in_ready got=%b exp=0", in_ready); end
        consume();
        issue(4'b1010, 32'h8000_0000, 32'd4, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL sra4_latency got=%0d exp=5", lat); end
        checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra4_result got=%h exp=f8000000", result); end
        consume();
        issue(4'b1010, 32'h8765_4321, 32'h20, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sra0_latency got=%0d exp=1", lat); end
        checks++; if (result !== 32'h8765_4321) begin errors++; $display("FAIL sra0_result got=%h exp=87654321", result); end
        consume();
        issue(4'b1001, 32'h8000_0001, 32'd1, lat);
        checks++; if ({result, zero} !== {32'h2, 1'b0}) begin errors++; $display("FAIL sll1_result got=%h/%b exp=00000002/0", result, zero); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); alu_ctrl = 4'b0010; src_a = i; src_b = 32'h100;
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_handshake got=%b exp=10", {out_valid, in_ready}); end
            checks++; if (result !== 32'hA5A5_5A5A) begin errors++; $display("FAIL bp_result got=%h exp=a5a55a5a", result); end
        end
        in_valid = 1'b0;
        consume();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid}); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_stale got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        int lat;
        issue(4'b0101, 32'd5, 32'd3, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        checks++; if ({result, zero, illegal} !== {32'h0, 2'b11}) begin errors++; $display("FAIL illegal_out got=%h/%b exp=00000000/11", result, {zero, illegal}); end
        consume();
        issue(4'b0010, 32'd2, 32'd3, lat);
        checks++; if ({result, zero, illegal} !== {32'd5, 2'b00}) begin errors++; $display("FAIL illegal_clear got=%h/%b exp=00000005/00", result, {zero, illegal}); end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int stale;
        alu_ctrl = 4'b1001; src_a = 32'h1; src_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst_shift_state got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_shift_result got=%h exp=0", result); end
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rst_shift_stale got=%0d exp=0", stale); end
        issue(4'b0010, 32'd40, 32'd2, lat);
        checks++; if ({lat, result} !== {32'd1, 32'd42}) begin errors++; $display("FAIL rst_shift_after got=%0d/%h exp=1/0000002a", lat, result); end
        consume();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt_logic();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
